// File: rtl/logbuf_arb.sv
// Log buffer sequencer: arbitrates the shared stb/we/addr port between the CPU and hardware
// event sources, writes hardware records into the ring and tracks shadow put/get indices.
module logbuf_arb #(
    parameter int NUM_REQ     = 2,
    parameter int NUM_ENTRIES = 32,
    parameter int REC_BYTES   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_stb,
    input  logic                  i_cpu_we,
    input  logic                  i_cpu_addr,
    input  logic [31:0]           i_cpu_din,
    output logic [31:0]           o_cpu_dout,
    output logic                  o_cpu_ack,
    input  logic [NUM_REQ-1:0]    i_hw_req,
    input  logic [32*NUM_REQ-1:0] i_hw_data,
    output logic [NUM_REQ-1:0]    o_hw_gnt,
    output logic                  o_lb_stb,
    output logic                  o_lb_we,
    output logic                  o_lb_addr,
    output logic [31:0]           o_lb_din,
    input  logic [31:0]           i_lb_dout,
    output logic [7:0]            o_ovf_cnt,
    output logic                  o_busy
);
    localparam int         IX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int         RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] LAST_BYTE = 3'(REC_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CPU     = 3'd1,
        S_SET_IX  = 3'd2,
        S_WR_BYTE = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic                 r_lb_stb,  w_lb_stb_nxt;
    logic                 r_lb_we,   w_lb_we_nxt;
    logic                 r_lb_addr, w_lb_addr_nxt;
    logic [31:0]          r_lb_din,  w_lb_din_nxt;
    logic                 r_cpu_ack, w_cpu_ack_nxt;
    logic [31:0]          r_cpu_dout, w_cpu_dout_nxt;
    logic [NUM_REQ-1:0]   r_hw_gnt,  w_hw_gnt_nxt;
    logic                 r_busy;
    logic [IX_W-1:0]      r_put,     w_put_nxt;
    logic [IX_W-1:0]      r_get,     w_get_nxt;
    logic [7:0]           r_ovf,     w_ovf_nxt;
    logic [RR_W-1:0]      r_rr,      w_rr_nxt;
    logic [RR_W-1:0]      r_win,     w_win_nxt;
    logic [31:0]          r_rec,     w_rec_nxt;
    logic [2:0]           r_cnt,     w_cnt_nxt;

    logic [NUM_REQ-1:0]   w_req_elig;
    logic [RR_W-1:0]      w_pick;
    logic [31:0]          w_rec_sel;
    logic [IX_W-1:0]      w_put_n;
    logic [IX_W-1:0]      w_get_n;
    logic                 w_full;
    logic [7:0]           w_ovf_n;

    function automatic logic [31:0] idx_word(input logic [IX_W-1:0] put, input logic [IX_W-1:0] get);
        return {16'(put), 16'(get)};
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] rec, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = rec[7:0];
            3'd1:    b = rec[15:8];
            3'd2:    b = rec[23:16];
            3'd3:    b = rec[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [RR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [RR_W-1:0] ptr);
        logic [RR_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = RR_W'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // A source whose grant is showing this cycle still holds its request; it must not restart.
    assign w_req_elig = i_hw_req & ~r_hw_gnt;
    assign w_pick     = rr_pick(w_req_elig, r_rr);
    assign w_rec_sel  = i_hw_data[32*w_pick +: 32];

    assign w_put_n = r_put + IX_W'(1);
    assign w_full  = (w_put_n == r_get);
    assign w_get_n = w_full ? (r_get + IX_W'(1)) : r_get;
    assign w_ovf_n = (w_full && (r_ovf != 8'd255)) ? (r_ovf + 8'd1) : r_ovf;

    // Next-state and next-output decode; all bus outputs are registered from these values.
    always_comb begin
        w_state_nxt    = r_state;
        w_lb_stb_nxt   = 1'b0;
        w_lb_we_nxt    = 1'b0;
        w_lb_addr_nxt  = 1'b0;
        w_lb_din_nxt   = 32'd0;
        w_cpu_ack_nxt  = 1'b0;
        w_cpu_dout_nxt = 32'd0;
        w_hw_gnt_nxt   = '0;
        w_put_nxt      = r_put;
        w_get_nxt      = r_get;
        w_ovf_nxt      = r_ovf;
        w_rr_nxt       = r_rr;
        w_win_nxt      = r_win;
        w_rec_nxt      = r_rec;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_stb && !r_cpu_ack) begin
                    w_state_nxt   = S_CPU;
                    w_lb_stb_nxt  = 1'b1;
                    w_lb_we_nxt   = i_cpu_we;
                    w_lb_addr_nxt = i_cpu_addr;
                    w_lb_din_nxt  = i_cpu_din;
                end else if (|w_req_elig) begin
                    w_state_nxt   = S_SET_IX;
                    w_win_nxt     = w_pick;
                    w_rec_nxt     = w_rec_sel;
                    w_lb_stb_nxt  = 1'b1;
                    w_lb_we_nxt   = 1'b1;
                    w_lb_addr_nxt = 1'b1;
                    w_lb_din_nxt  = idx_word(r_put, r_get);
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_CPU: begin
                w_state_nxt    = S_IDLE;
                w_cpu_ack_nxt  = 1'b1;
                w_cpu_dout_nxt = i_lb_dout;
                if (r_lb_we && r_lb_addr) begin
                    w_put_nxt = r_lb_din[16 +: IX_W];
                    w_get_nxt = r_lb_din[0 +: IX_W];
                end else begin
                    w_put_nxt = r_put;
                    w_get_nxt = r_get;
                end
            end
            S_SET_IX: begin
                w_state_nxt  = S_WR_BYTE;
                w_cnt_nxt    = 3'd0;
                w_lb_stb_nxt = 1'b1;
                w_lb_we_nxt  = 1'b1;
                w_lb_din_nxt = {24'd0, byte_sel(r_rec, 3'd0)};
            end
            S_WR_BYTE: begin
                w_lb_stb_nxt = 1'b1;
                w_lb_we_nxt  = 1'b1;
                if (r_cnt == LAST_BYTE) begin
                    w_state_nxt   = S_ADVANCE;
                    w_lb_addr_nxt = 1'b1;
                    w_lb_din_nxt  = idx_word(w_put_n, w_get_n);
                end else begin
                    w_cnt_nxt     = r_cnt + 3'd1;
                    w_lb_din_nxt  = {24'd0, byte_sel(r_rec, r_cnt + 3'd1)};
                end
            end
            S_ADVANCE: begin
                w_state_nxt  = S_IDLE;
                w_put_nxt    = w_put_n;
                w_get_nxt    = w_get_n;
                w_ovf_nxt    = w_ovf_n;
                w_hw_gnt_nxt = NUM_REQ'(1) << r_win;
                w_rr_nxt     = (r_win == RR_W'(NUM_REQ - 1)) ? RR_W'(0) : (r_win + RR_W'(1));
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, shadow indices and registered outputs; reset drops any record in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lb_stb   <= 1'b0;
            r_lb_we    <= 1'b0;
            r_lb_addr  <= 1'b0;
            r_lb_din   <= 32'd0;
            r_cpu_ack  <= 1'b0;
            r_cpu_dout <= 32'd0;
            r_hw_gnt   <= '0;
            r_busy     <= 1'b0;
            r_put      <= '0;
            r_get      <= '0;
            r_ovf      <= 8'd0;
            r_rr       <= '0;
            r_win      <= '0;
            r_rec      <= 32'd0;
            r_cnt      <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lb_stb   <= w_lb_stb_nxt;
            r_lb_we    <= w_lb_we_nxt;
            r_lb_addr  <= w_lb_addr_nxt;
            r_lb_din   <= w_lb_din_nxt;
            r_cpu_ack  <= w_cpu_ack_nxt;
            r_cpu_dout <= w_cpu_dout_nxt;
            r_hw_gnt   <= w_hw_gnt_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_put      <= w_put_nxt;
            r_get      <= w_get_nxt;
            r_ovf      <= w_ovf_nxt;
            r_rr       <= w_rr_nxt;
            r_win      <= w_win_nxt;
            r_rec      <= w_rec_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign o_lb_stb   = r_lb_stb;
    assign o_lb_we    = r_lb_we;
    assign o_lb_addr  = r_lb_addr;
    assign o_lb_din   = r_lb_din;
    assign o_cpu_ack  = r_cpu_ack;
    assign o_cpu_dout = r_cpu_dout;
    assign o_hw_gnt   = r_hw_gnt;
    assign o_ovf_cnt  = r_ovf;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_logbuf_arb.sv
// Bench for logbuf_arb: log buffer model, directed vector table, corner sequences and a
// randomized phase checked against a transaction-level ring/arbitration model.
module tb_logbuf_arb;
    localparam int NR = 2;
    localparam int NE = 32;
    localparam int RB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_stb, cpu_we, cpu_addr;
    logic [31:0]      cpu_din, cpu_dout;
    logic             cpu_ack;
    logic [NR-1:0]    hw_req, hw_gnt;
    logic [32*NR-1:0] hw_data;
    logic             lb_stb, lb_we, lb_addr;
    logic [31:0]      lb_din, lb_dout;
    logic [7:0]       ovf_cnt;
    logic             busy;

    logic [31:0]      buf_idx  = 32'd0;
    logic [31:0]      buf_data = 32'd0;
    logic [32:0]      wlog[$];
    logic [32:0]      expq[$];

    int               checks = 0;
    int               errors = 0;
    int               m_put = 0, m_get = 0, m_ovf = 0, m_rr = 0;
    logic [31:0]      m_buf_idx = 32'd0;

    logbuf_arb #(.NUM_REQ(NR), .NUM_ENTRIES(NE), .REC_BYTES(RB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_stb(cpu_stb), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
        .o_cpu_dout(cpu_dout), .o_cpu_ack(cpu_ack),
        .i_hw_req(hw_req), .i_hw_data(hw_data), .o_hw_gnt(hw_gnt),
        .o_lb_stb(lb_stb), .o_lb_we(lb_we), .o_lb_addr(lb_addr), .o_lb_din(lb_din),
        .i_lb_dout(lb_dout), .o_ovf_cnt(ovf_cnt), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Log buffer: index register and last data word, read combinationally by address.
    assign lb_dout = lb_addr ? buf_idx : buf_data;
    always @(posedge clk) begin
        if (lb_stb && lb_we && lb_addr) buf_idx <= lb_din;
        if (lb_stb && lb_we && !lb_addr) buf_data <= lb_din;
    end

    always @(posedge clk) begin
        if (lb_stb && lb_we) wlog.push_back({lb_addr, lb_din});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] idxw(input int p, input int g);
        logic [31:0] r;
        r = {p[15:0], g[15:0]};
        return r;
    endfunction

    function automatic void model_cpu_write(input logic [31:0] v);
        m_put     = int'(v[31:16]) % NE;
        m_get     = int'(v[15:0]) % NE;
        m_buf_idx = v;
    endfunction

    function automatic void model_record(input int src, input logic [31:0] data, input bit push);
        int pn;
        if (push) begin
            expq.push_back({1'b1, idxw(m_put, m_get)});
            for (int k = 0; k < RB; k++) expq.push_back({1'b0, 24'd0, data[8*k +: 8]});
        end
        pn = (m_put + 1) % NE;
        if (pn == m_get) begin
            m_get = (m_get + 1) % NE;
            if (m_ovf < 255) m_ovf++;
        end
        m_put     = pn;
        m_rr      = (src + 1) % NR;
        m_buf_idx = idxw(m_put, m_get);
        if (push) expq.push_back({1'b1, m_buf_idx});
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic cmp_writes(input string name);
        while (expq.size() > 0) begin
            logic [32:0] e;
            e = expq.pop_front();
            if (wlog.size() == 0) chk(name, 64'h1_dead_dead, {31'd0, e});
            else chk(name, {31'd0, wlog.pop_front()}, {31'd0, e});
        end
        chk({name, "_extra"}, wlog.size(), 0);
        wlog.delete();
    endtask

    task automatic cpu_access(input logic we, input logic addr, input logic [31:0] din,
                              output logic [31:0] dout);
        int lat;
        lat = -1;
        dout = 32'd0;
        cpu_stb = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (cpu_ack) begin
                lat = t;
                dout = cpu_dout;
                break;
            end
        end
        cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_din = 32'd0;
        chk("cpu_latency", lat, 2);
        tick();
        chk("cpu_ack_pulse", cpu_ack, 1'b0);
        chk("cpu_dout_idle", cpu_dout, 32'd0);
    endtask

    task automatic wait_gnt(input int src, output int lat);
        lat = -1;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (hw_gnt != '0) begin
                lat = t;
                break;
            end
        end
        if (lat < 0) chk("gnt_timeout", 64'd0, 64'd1);
        else chk("gnt_vec", hw_gnt, NR'(1) << src);
        hw_req[src] = 1'b0;
        tick();
        chk("gnt_pulse", hw_gnt, '0);
    endtask

    task automatic hw_record(input int src, input logic [31:0] data);
        int lat;
        wlog.delete();
        hw_data[32*src +: 32] = data;
        hw_req[src] = 1'b1;
        model_record(src, data, 1'b1);
        wait_gnt(src, lat);
        chk("rec_latency", lat, 7);
        cmp_writes("rec_writes");
    endtask

    typedef struct {
        bit          pre;
        logic [31:0] pre_idx;
        int          src;
        logic [31:0] data;
        logic [31:0] first_idx;
        logic [31:0] last_idx;
        logic [7:0]  ovf;
    } vec_t;

    vec_t          vt[6];
    logic [31:0]   d;
    int            lat, n, guard, w, gt, at;
    logic [NR-1:0] pend, prev;

    initial begin
        vt[0] = '{1'b0, 32'h0,        0, 32'h44332211, 32'h00000000, 32'h00010000, 8'd0};
        vt[1] = '{1'b0, 32'h0,        1, 32'hDEADBEEF, 32'h00010000, 32'h00020000, 8'd0};
        vt[2] = '{1'b1, 32'h001F0000, 0, 32'h0000A5C3, 32'h001F0000, 32'h00000001, 8'd1};
        vt[3] = '{1'b1, 32'h00050006, 1, 32'h12345678, 32'h00050006, 32'h00060007, 8'd2};
        vt[4] = '{1'b1, 32'h01230045, 0, 32'h9ABCDEF0, 32'h00030005, 32'h00040005, 8'd2};
        vt[5] = '{1'b0, 32'h0,        0, 32'hFF00FF00, 32'h00040005, 32'h00050006, 8'd3};

        rst = 1'b1;
        cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_din = 32'd0;
        hw_req = '0; hw_data = '0;
        tick(); tick();
        chk("rst_lb_stb", lb_stb, 1'b0);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_hw_gnt", hw_gnt, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf_cnt, 8'd0);
        chk("rst_cpu_dout", cpu_dout, 32'd0);
        rst = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            if (vt[i].pre) begin
                cpu_access(1'b1, 1'b1, vt[i].pre_idx, d);
                model_cpu_write(vt[i].pre_idx);
            end
            wlog.delete();
            expq.delete();
            expq.push_back({1'b1, vt[i].first_idx});
            for (int k = 0; k < RB; k++) expq.push_back({1'b0, 24'd0, vt[i].data[8*k +: 8]});
            expq.push_back({1'b1, vt[i].last_idx});
            model_record(vt[i].src, vt[i].data, 1'b0);
            hw_data[32*vt[i].src +: 32] = vt[i].data;
            hw_req[vt[i].src] = 1'b1;
            wait_gnt(vt[i].src, lat);
            chk("vec_latency", lat, 7);
            cmp_writes("vec_writes");
            chk("vec_ovf", ovf_cnt, vt[i].ovf);
            cpu_access(1'b0, 1'b1, 32'd0, d);
            chk("vec_rd_idx", d, vt[i].last_idx);
        end

        // Both sources held: strict round-robin alternation
        wlog.delete();
        hw_data = {32'hBBBB0001, 32'hAAAA0000};
        hw_req = 2'b11;
        n = 0; guard = 0; prev = '0;
        while (n < 4 && guard < 100) begin
            tick();
            guard++;
            if (hw_gnt != '0) begin
                w = rr_pick(2'b11);
                chk("rr_gnt", hw_gnt, NR'(1) << w);
                if (n > 0) chk("rr_no_repeat", (hw_gnt == prev), 1'b0);
                model_record(w, hw_data[32*w +: 32], 1'b1);
                cmp_writes("rr_writes");
                prev = hw_gnt;
                n++;
            end
        end
        hw_req = '0;
        chk("rr_count", n, 4);
        tick();

        // CPU request arriving during WR_BYTE waits for ADVANCE and one IDLE cycle
        wlog.delete();
        hw_data[31:0] = 32'hCAFEF00D;
        hw_req[0] = 1'b1;
        model_record(0, 32'hCAFEF00D, 1'b1);
        gt = -1; at = -1; d = 32'd0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 3) begin
                chk("mid_busy", busy, 1'b1);
                cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 1'b1;
            end
            if (hw_gnt[0] && gt < 0) begin
                gt = t;
                hw_req[0] = 1'b0;
            end
            if (cpu_ack && at < 0) begin
                at = t;
                d = cpu_dout;
                cpu_stb = 1'b0; cpu_addr = 1'b0;
            end
            if (gt >= 0 && at >= 0) break;
        end
        cpu_stb = 1'b0;
        chk("mid_gnt_cycle", gt, 7);
        chk("mid_ack_cycle", at, 9);
        chk("mid_rd_idx", d, m_buf_idx);
        cmp_writes("mid_writes");
        tick();

        // Randomized operations against the model
        for (int op = 0; op < 80; op++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                logic [31:0] v;
                v = $urandom;
                cpu_access(1'b1, 1'b1, v, d);
                model_cpu_write(v);
            end else if (r == 2) begin
                cpu_access(1'b0, 1'b1, 32'd0, d);
                chk("rnd_rd_idx", d, m_buf_idx);
            end else begin
                wlog.delete();
                pend = NR'($urandom_range(1, (1 << NR) - 1));
                for (int i = 0; i < NR; i++) begin
                    if (pend[i]) begin
                        hw_data[32*i +: 32] = $urandom;
                        hw_req[i] = 1'b1;
                    end
                end
                guard = 0;
                while (pend != '0 && guard < 200) begin
                    tick();
                    guard++;
                    if (hw_gnt != '0) begin
                        w = rr_pick(pend);
                        chk("rnd_gnt", hw_gnt, NR'(1) << w);
                        model_record(w, hw_data[32*w +: 32], 1'b1);
                        cmp_writes("rnd_writes");
                        pend[w] = 1'b0;
                        hw_req[w] = 1'b0;
                    end
                end
                chk("rnd_pending", pend, '0);
                hw_req = '0;
                tick();
                chk("rnd_ovf", ovf_cnt, m_ovf);
            end
        end

        // 300 records with no reads: overflow count saturates, indices stay in range
        cpu_access(1'b1, 1'b1, 32'd0, d);
        model_cpu_write(32'd0);
        for (int i = 0; i < 300; i++) hw_record(i % NR, $urandom);
        chk("sat_ovf_255", ovf_cnt, 8'd255);
        chk("sat_ovf_model", ovf_cnt, m_ovf);
        cpu_access(1'b0, 1'b1, 32'd0, d);
        chk("sat_put_range", (d[31:16] < 16'd32), 1'b1);
        chk("sat_get_range", (d[15:0] < 16'd32), 1'b1);
        chk("sat_rd_idx", d, m_buf_idx);

        // Asynchronous reset in the middle of WR_BYTE
        wlog.delete();
        hw_data[31:0] = 32'h0BADBEEF;
        hw_req[0] = 1'b1;
        tick(); tick(); tick();
        chk("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_stb", lb_stb, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_gnt", hw_gnt, '0);
        tick(); tick();
        chk("rst_hold_gnt", hw_gnt, '0);
        chk("rst_hold_ovf", ovf_cnt, 8'd0);
        rst = 1'b0;
        m_put = 0; m_get = 0; m_ovf = 0; m_rr = 0;
        wlog.delete();
        expq.delete();
        model_record(0, 32'h0BADBEEF, 1'b1);
        wait_gnt(0, lat);
        chk("rst_rec_latency", lat, 7);
        cmp_writes("rst_rec_writes");
        chk("rst_rec_ovf", ovf_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
